// File: rtl/cpu_pkg.sv
// Shared CPU definitions: FPU op encoding (also used by the decoder),
// FP issue controller states and NZCV flag bit positions.
package cpu_pkg;

  typedef enum logic [1:0] {
    FP_ADD = 2'b00,
    FP_SUB = 2'b01,
    FP_MUL = 2'b10,
    FP_DIV = 2'b11
  } fpu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } fpu_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/fpu_hazard_check.sv
// Operand hazard detection for the instruction in decode against the
// single in-flight FP result. Purely combinational.
module fpu_hazard_check (
  input  logic       in_flight,
  input  logic       releasing,
  input  logic       cmp,
  input  logic [2:0] rd,
  input  logic [2:0] dec_rs1,
  input  logic [2:0] dec_rs2,
  input  logic [1:0] dec_rs_valid,
  input  logic       dec_reads_flags,
  output logic       hazard_stall
);

  logic reg_hit;
  logic flag_hit;

  // Compare sources (or flags use) with the pending destination; the
  // grant cycle releases the stall since the register file forwards it.
  always_comb begin
    reg_hit  = ~cmp & ((dec_rs_valid[0] & (dec_rs1 == rd)) |
                       (dec_rs_valid[1] & (dec_rs2 == rd)));
    flag_hit = cmp & dec_reads_flags;
    hazard_stall = in_flight & ~releasing & (reg_hit | flag_hit);
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: accepts one FP instruction, starts the FPU, times
// its fixed latency, captures the result and requests writeback.
//
//   state | meaning
//   IDLE  | ready to accept an FP instruction
//   EXEC  | FPU busy, latency counter running down
//   WB    | result captured, requesting the writeback port
module fpu_issue_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [1:0]        issue_op,
  input  logic              issue_cmp,
  input  logic [2:0]        issue_rd,
  output logic              issue_ready,
  input  logic [2:0]        dec_rs1,
  input  logic [2:0]        dec_rs2,
  input  logic [1:0]        dec_rs_valid,
  input  logic              dec_reads_flags,
  output logic              hazard_stall,
  output logic              fpu_start,
  output logic [1:0]        fpu_op,
  input  logic [DATA_W-1:0] fpu_result,
  input  logic [3:0]        fpu_flags,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_grant,
  output logic [2:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_reg_en,
  output logic              wb_flags_en,
  output logic [3:0]        wb_flags
);

  fpu_state_t        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  fpu_op_t           op_q, op_nx;
  logic [2:0]        rd_q, rd_nx;
  logic              cmp_q, cmp_nx;
  logic              start_q, start_nx;
  logic [DATA_W-1:0] data_q, data_nx;
  logic [3:0]        flags_q, flags_nx;

  // Counter load value is latency minus one; FCMP always runs at add latency.
  function automatic logic [CNT_W-1:0] lat_m1(input fpu_op_t op, input logic cmp);
    int lat;
    if (cmp || op == FP_ADD || op == FP_SUB) lat = ADD_LAT;
    else if (op == FP_MUL)                   lat = MUL_LAT;
    else                                     lat = DIV_LAT;
    return CNT_W'(lat - 1);
  endfunction

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= FP_ADD;
      rd_q    <= '0;
      cmp_q   <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      op_q    <= op_nx;
      rd_q    <= rd_nx;
      cmp_q   <= cmp_nx;
      start_q <= start_nx;
      data_q  <= data_nx;
      flags_q <= flags_nx;
    end
  end

  // Next-state logic; flush outranks both counter expiry and grant.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_nx    = op_q;
    rd_nx    = rd_q;
    cmp_nx   = cmp_q;
    start_nx = 1'b0;
    data_nx  = data_q;
    flags_nx = flags_q;
    unique case (state)
      IDLE: begin
        if (issue_valid && !flush) begin
          state_nx = EXEC;
          op_nx    = fpu_op_t'(issue_op);
          rd_nx    = issue_rd;
          cmp_nx   = issue_cmp;
          cnt_nx   = lat_m1(fpu_op_t'(issue_op), issue_cmp);
          start_nx = 1'b1;
        end
      end
      EXEC: begin
        if (flush) begin
          state_nx = IDLE;
        end else if (cnt == '0) begin
          state_nx = WB;
          data_nx  = fpu_result;
          flags_nx = fpu_flags;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      WB: begin
        if (flush || wb_grant) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output decode; a flush in the WB cycle withdraws the request so a
  // coincident grant writes nothing.
  always_comb begin
    issue_ready = (state == IDLE);
    fpu_start   = start_q;
    fpu_op      = op_q;
    wb_valid    = (state == WB) && !flush;
    wb_rd       = rd_q;
    wb_data     = data_q;
    wb_flags    = flags_q;
    wb_reg_en   = wb_valid & ~cmp_q;
    wb_flags_en = wb_valid & cmp_q;
  end

  fpu_hazard_check u_hazard (
    .in_flight       (state != IDLE),
    .releasing       (wb_valid & wb_grant),
    .cmp             (cmp_q),
    .rd              (rd_q),
    .dec_rs1         (dec_rs1),
    .dec_rs2         (dec_rs2),
    .dec_rs_valid    (dec_rs_valid),
    .dec_reads_flags (dec_reads_flags),
    .hazard_stall    (hazard_stall)
  );

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: reset checks, hand-written latency/arbitration/
// flush/reset sequences, a hazard vector table and a random run against a
// transaction-level reference model.
module tb_fpu_issue_ctrl;

  localparam int DATA_W  = 16;
  localparam int ADD_LAT = 2;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;
  localparam int CNT_W   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              issue_valid;
  logic [1:0]        issue_op;
  logic              issue_cmp;
  logic [2:0]        issue_rd;
  logic              issue_ready;
  logic [2:0]        dec_rs1, dec_rs2;
  logic [1:0]        dec_rs_valid;
  logic              dec_reads_flags;
  logic              hazard_stall;
  logic              fpu_start;
  logic [1:0]        fpu_op;
  logic [DATA_W-1:0] fpu_result;
  logic [3:0]        fpu_flags;
  logic              flush;
  logic              wb_valid;
  logic              wb_grant;
  logic [2:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_reg_en;
  logic              wb_flags_en;
  logic [3:0]        wb_flags;

  int checks = 0;
  int errors = 0;

  fpu_issue_ctrl #(
    .DATA_W(DATA_W), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_cmp(issue_cmp),
    .issue_rd(issue_rd), .issue_ready(issue_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs_valid(dec_rs_valid),
    .dec_reads_flags(dec_reads_flags), .hazard_stall(hazard_stall),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_result(fpu_result),
    .fpu_flags(fpu_flags), .flush(flush), .wb_valid(wb_valid),
    .wb_grant(wb_grant), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_reg_en(wb_reg_en), .wb_flags_en(wb_flags_en), .wb_flags(wb_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_op = 0; issue_cmp = 0; issue_rd = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rs_valid = 0; dec_reads_flags = 0;
    fpu_result = 0; fpu_flags = 0; flush = 0; wb_grant = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    tick(); tick();
    reset = 1;
  endtask

  function automatic int lat_of(input logic [1:0] op, input logic cmp);
    if (cmp) return ADD_LAT;
    case (op)
      2'b10:   return MUL_LAT;
      2'b11:   return DIV_LAT;
      default: return ADD_LAT;
    endcase
  endfunction

  typedef struct {
    logic [1:0] op;
    logic       cmp;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [1:0] rsv;
    logic       rf;
    logic       grant;
    logic       exp_stall;
  } hz_vec_t;

  hz_vec_t hz_tab[10];

  // Reference model: one outstanding instruction, tracked by its age in
  // cycles since acceptance (age 1 = FPU start cycle).
  bit          m_busy;
  int          m_age, m_lat;
  logic [1:0]  m_op;
  logic        m_cmp;
  logic [2:0]  m_rd;
  logic [15:0] m_data;
  logic [3:0]  m_flags;

  initial begin
    idle_inputs();
    reset = 0;
    tick(); tick();
    // reset state
    check("rst_ready", issue_ready, 1);
    check("rst_start", fpu_start, 0);
    check("rst_wbv", wb_valid, 0);
    check("rst_fpu_op", fpu_op, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_flags", wb_flags, 0);
    check("rst_stall", hazard_stall, 0);
    reset = 1;

    // FADD latency with grant tied high
    tick();
    issue_valid = 1; issue_op = 2'b00; issue_cmp = 0; issue_rd = 3;
    fpu_result = 16'h4200; wb_grant = 1;
    #1 check("t1_ready_accept", issue_ready, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      issue_valid = 0;
      #1;
      check("t1_start", fpu_start, (k == 1));
      check("t1_wbv", wb_valid, (k == 3));
      if (k == 3) begin
        check("t1_reg_en", wb_reg_en, 1);
        check("t1_flags_en", wb_flags_en, 0);
        check("t1_wb_rd", wb_rd, 3);
        check("t1_wb_data", wb_data, 16'h4200);
      end
      check("t1_ready", issue_ready, (k == 4));
    end

    // FDIV with grant withheld four cycles; result varies every cycle
    do_reset();
    issue_valid = 1; issue_op = 2'b11; issue_rd = 5; wb_grant = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      issue_valid = 0;
      fpu_result = 16'h1000 + 16'(k);
      wb_grant = (k == 13);
      #1;
      check("t2_wbv", wb_valid, (k >= 9 && k <= 13));
      if (k >= 9 && k <= 13) begin
        check("t2_wb_data", wb_data, 16'h1008);
        check("t2_wb_rd", wb_rd, 5);
      end
      check("t2_fpu_op", fpu_op, 2'b11);
      check("t2_ready", issue_ready, (k == 14));
    end

    // FCMP: flags only, flag hazard but no register hazard
    do_reset();
    issue_valid = 1; issue_op = 2'b01; issue_cmp = 1; issue_rd = 6;
    fpu_flags = 4'b1011; wb_grant = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      issue_valid = 0;
      fpu_flags = (k == 2) ? 4'b0100 : 4'b1011;
      dec_reads_flags = 1; dec_rs1 = 0; dec_rs_valid = 2'b00;
      #1;
      if (k == 1) begin
        check("t3_flag_stall", hazard_stall, 1);
        dec_reads_flags = 0; dec_rs1 = 6; dec_rs_valid = 2'b01;
        #1 check("t3_no_reg_stall", hazard_stall, 0);
      end
      if (k == 3) begin
        check("t3_wbv", wb_valid, 1);
        check("t3_flags_en", wb_flags_en, 1);
        check("t3_reg_en", wb_reg_en, 0);
        check("t3_wb_flags", wb_flags, 4'b0100);
      end
    end

    // hazard vector table, evaluated while the op waits in writeback
    hz_tab[0] = '{2'b10, 0, 3'd2, 3'd0, 3'd2, 2'b10, 0, 0, 1};
    hz_tab[1] = '{2'b10, 0, 3'd4, 3'd0, 3'd2, 2'b10, 0, 0, 0};
    hz_tab[2] = '{2'b10, 0, 3'd2, 3'd0, 3'd2, 2'b01, 0, 0, 0};
    hz_tab[3] = '{2'b10, 0, 3'd2, 3'd2, 3'd7, 2'b01, 0, 0, 1};
    hz_tab[4] = '{2'b10, 0, 3'd2, 3'd2, 3'd2, 2'b00, 0, 0, 0};
    hz_tab[5] = '{2'b10, 0, 3'd2, 3'd0, 3'd2, 2'b10, 0, 1, 0};
    hz_tab[6] = '{2'b01, 1, 3'd6, 3'd0, 3'd0, 2'b00, 1, 0, 1};
    hz_tab[7] = '{2'b01, 1, 3'd6, 3'd6, 3'd6, 2'b11, 0, 0, 0};
    hz_tab[8] = '{2'b00, 0, 3'd7, 3'd1, 3'd1, 2'b00, 1, 0, 0};
    hz_tab[9] = '{2'b11, 0, 3'd0, 3'd0, 3'd0, 2'b11, 0, 0, 1};
    for (int i = 0; i < 10; i++) begin
      do_reset();
      issue_valid = 1; issue_op = hz_tab[i].op; issue_cmp = hz_tab[i].cmp;
      issue_rd = hz_tab[i].rd;
      for (int k = 1; k <= 10; k++) begin
        tick();
        issue_valid = 0;
      end
      dec_rs1 = hz_tab[i].rs1; dec_rs2 = hz_tab[i].rs2;
      dec_rs_valid = hz_tab[i].rsv; dec_reads_flags = hz_tab[i].rf;
      wb_grant = hz_tab[i].grant;
      #1;
      check("tab_wbv", wb_valid, 1);
      check($sformatf("tab_stall[%0d]", i), hazard_stall, hz_tab[i].exp_stall);
    end

    // flush in the second EXEC cycle of FDIV
    do_reset();
    issue_valid = 1; issue_op = 2'b11; issue_rd = 2; wb_grant = 1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      issue_valid = 0;
      flush = (k == 2);
      #1;
      if (k >= 3) begin
        check("t5a_wbv", wb_valid, 0);
        check("t5a_ready", issue_ready, 1);
      end
    end

    // flush in WB together with grant
    do_reset();
    issue_valid = 1; issue_op = 2'b00; issue_rd = 1; wb_grant = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      issue_valid = 0;
      flush = (k == 3);
      wb_grant = (k == 3);
      #1;
      if (k == 3) begin
        check("t5b_wbv_flush", wb_valid, 0);
        check("t5b_reg_en_flush", wb_reg_en, 0);
      end
      if (k >= 4) begin
        check("t5b_wbv_after", wb_valid, 0);
        check("t5b_ready", issue_ready, 1);
      end
    end

    // busy issue ignored, then reset during WB
    do_reset();
    issue_valid = 1; issue_op = 2'b10; issue_rd = 5; wb_grant = 0;
    fpu_result = 16'hBEEF; fpu_flags = 4'hF;
    for (int k = 1; k <= 7; k++) begin
      tick();
      issue_valid = (k <= 5); issue_op = 2'b00; issue_rd = 1;
      reset = (k != 5);
      #1;
      if (k <= 4) check("t6_start", fpu_start, (k == 1));
      if (k <= 4) check("t6_ready_busy", issue_ready, 0);
      if (k == 4) begin
        check("t6_wbv", wb_valid, 1);
        check("t6_wb_data", wb_data, 16'hBEEF);
      end
      if (k == 6) begin
        check("t6_rst_wbv", wb_valid, 0);
        check("t6_rst_start", fpu_start, 0);
        check("t6_rst_fpu_op", fpu_op, 0);
        check("t6_rst_wb_rd", wb_rd, 0);
        check("t6_rst_wb_data", wb_data, 0);
        check("t6_rst_wb_flags", wb_flags, 0);
        check("t6_rst_ready", issue_ready, 1);
      end
      if (k == 7) check("t6_no_restart", fpu_start, 0);
    end

    // random run against the reference model
    do_reset();
    m_busy = 0; m_age = 0; m_lat = 0; m_op = 0; m_cmp = 0; m_rd = 0;
    m_data = 0; m_flags = 0;
    for (int n = 0; n < 3000; n++) begin
      bit e_wbv;
      bit hit;
      tick();
      reset = ($urandom_range(0, 99) != 0);
      issue_valid = $urandom_range(0, 1);
      issue_op = 2'($urandom_range(0, 3));
      issue_cmp = (issue_op == 2'b01) && ($urandom_range(0, 1) == 1);
      issue_rd = 3'($urandom_range(0, 7));
      dec_rs1 = 3'($urandom_range(0, 7));
      dec_rs2 = 3'($urandom_range(0, 7));
      dec_rs_valid = 2'($urandom_range(0, 3));
      dec_reads_flags = $urandom_range(0, 1);
      fpu_result = 16'($urandom);
      fpu_flags = 4'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      wb_grant = ($urandom_range(0, 9) < 6);
      #1;
      e_wbv = m_busy && (m_age > m_lat) && !flush;
      if (m_cmp) hit = dec_reads_flags;
      else hit = (dec_rs_valid[0] && dec_rs1 == m_rd) || (dec_rs_valid[1] && dec_rs2 == m_rd);
      check("rnd_ready", issue_ready, !m_busy);
      check("rnd_start", fpu_start, m_busy && m_age == 1);
      check("rnd_wbv", wb_valid, e_wbv);
      check("rnd_reg_en", wb_reg_en, e_wbv && !m_cmp);
      check("rnd_flags_en", wb_flags_en, e_wbv && m_cmp);
      check("rnd_fpu_op", fpu_op, m_op);
      check("rnd_stall", hazard_stall, m_busy && !(e_wbv && wb_grant) && hit);
      check("rnd_wb_rd", wb_rd, m_rd);
      check("rnd_wb_data", wb_data, m_data);
      check("rnd_wb_flags", wb_flags, m_flags);
      // advance the model by the edge that follows
      if (!reset) begin
        m_busy = 0; m_age = 0; m_op = 0; m_cmp = 0; m_rd = 0; m_data = 0; m_flags = 0;
      end else if (m_busy) begin
        if (flush) m_busy = 0;
        else if (e_wbv && wb_grant) m_busy = 0;
        else begin
          if (m_age == m_lat) begin
            m_data = fpu_result;
            m_flags = fpu_flags;
          end
          m_age++;
        end
      end else if (issue_valid && !flush) begin
        m_busy = 1; m_age = 1; m_lat = lat_of(issue_op, issue_cmp);
        m_op = issue_op; m_cmp = issue_cmp; m_rd = issue_rd;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Sequences the multi-cycle FPU behind the decode stage.
- Accepts one decoded FP instruction (FADD/FSUB/FMUL/FDIV/FCMP), pulses the FPU start and counts its fixed per-op latency.
- Captures the result and flags, then arbitrates for the shared register/flags writeback port; the ALU has priority on that port.
- Drives operand-hazard stalls for later instructions that depend on the in-flight FP result.

Parameters:
- DATA_W, 16, width of FPU result / register data.
- ADD_LAT, 2, FPU cycles for FADD/FSUB/FCMP (>=1).
- MUL_LAT, 3, FPU cycles for FMUL (>=1).
- DIV_LAT, 8, FPU cycles for FDIV (>=1).
- CNT_W, 4, latency counter width; must hold max latency minus 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- issue_valid  in  1  decode holds an FP instruction (ALUorFPU=1).
- issue_op  in  2  FPUOp encoding: 00 add, 01 sub, 10 mul, 11 div.
- issue_cmp  in  1  instruction is FCMP: flags only, no register write.
- issue_rd  in  3  destination register index.
- issue_ready  out  1  block can accept an issue this cycle.
- dec_rs1, dec_rs2  in  3 each  source indices of the instruction in decode.
- dec_rs_valid  in  2  bit0 qualifies dec_rs1, bit1 qualifies dec_rs2.
- dec_reads_flags  in  1  decode instruction is a conditional branch.
- hazard_stall  out  1  stall decode due to pending FP result.
- fpu_start  out  1  one-cycle start pulse to FPU.
- fpu_op  out  2  op held stable for the whole execution.
- fpu_result  in  DATA_W  FPU result.
- fpu_flags  in  4  FPU NZCV.
- flush  in  1  kill the in-flight FP op (branch redirect).
- wb_valid  out  1  writeback request.
- wb_grant  in  1  writeback port granted this cycle (0 while the ALU owns it).
- wb_rd  out  3  destination register.
- wb_data  out  DATA_W  captured result.
- wb_reg_en  out  1  register write; equals wb_valid & ~cmp.
- wb_flags_en  out  1  flags write, all four bits; equals wb_valid & cmp.
- wb_flags  out  4  captured NZCV.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, counter=0.
  - fpu_start=0, fpu_op=0, wb_valid=0, wb_rd=0, wb_data=0, wb_flags=0; pending rd/op/cmp registers cleared.
  - Reset mid-operation drops the op silently; no writeback.
- States: IDLE, EXEC, WB.
- IDLE:
  - issue_ready=1.
  - If issue_valid & ~flush at edge T: latch op/rd/cmp; counter = LAT(op)-1; go to EXEC.
- EXEC:
  - fpu_start=1 only in its first cycle (T+1).
  - fpu_op=latched op throughout EXEC.
  - Counter decrements each cycle.
  - In the cycle counter==0: capture fpu_result/fpu_flags, go to WB.
  - Net: EXEC lasts LAT cycles; wb_valid first asserts at T+LAT+1.
- WB:
  - wb_valid=1 and outputs held stable until wb_grant=1.
  - On grant: go to IDLE at the next edge.
  - A new issue cannot be accepted in the grant cycle (issue_ready=0 outside IDLE), so the earliest next accept is the grant cycle plus 1.
- issue_valid while not in IDLE: ignored. Decode is already stalled by issue_ready=0, and the pipeline must hold the instruction.
- flush:
  - In EXEC or WB: return to IDLE next edge; no wb_valid afterwards; a wb_grant in the same cycle is ignored.
  - In IDLE: blocks acceptance that cycle.
  - flush has priority over counter expiry and grant.
- hazard_stall (combinational) is asserted when state≠IDLE and any of:
  - ~cmp, dec_rs_valid[0] and dec_rs1==rd;
  - ~cmp, dec_rs_valid[1] and dec_rs2==rd;
  - cmp and dec_reads_flags.
  - hazard_stall deasserts in the grant cycle; the register file forwards writeback, so there is no extra bubble.
- LAT(op): add/sub → ADD_LAT, mul → MUL_LAT, div → DIV_LAT. FCMP (op 01, cmp=1) uses ADD_LAT.
- Counter never wraps: it is reloaded on accept and only decrements in EXEC.

Decomposition:
- Shared package cpu_pkg holds:
  - fpu_op_t enum (FP_ADD=2'b00, FP_SUB=2'b01, FP_MUL=2'b10, FP_DIV=2'b11), shared with the decoder.
  - fpu_state_t enum (IDLE, EXEC, WB).
  - Flag bit index constants (N=3, Z=2, C=1, V=0).
- One sub-module, fpu_hazard_check: purely combinational compare producing hazard_stall. Everything else stays in fpu_issue_ctrl.

Test Plan:
1. Latency: FADD op=00 rd=3 accepted at cycle 10, fpu_result=16'h4200, wb_grant tied 1 → fpu_start at 11 only; wb_valid, wb_reg_en at 13 with wb_rd=3, wb_data=16'h4200; issue_ready back at 14.
2. Arbitration: FDIV rd=5, wb_grant=0 for 4 cycles after wb_valid rises → wb_valid, wb_data stable all 4 cycles; IDLE one cycle after grant; wb_valid first at accept+9.
3. FCMP: fpu_flags=4'b0100 → wb_flags_en=1, wb_reg_en=0, wb_flags=4'b0100. During EXEC, dec_reads_flags=1 raises hazard_stall; dec_rs1=rd with dec_rs_valid=01 does not.
4. Register hazard: FMUL rd=2, decode dec_rs2=2, dec_rs_valid=10 → hazard_stall from accept+1 through the grant cycle exclusive; rd=4 → no stall.
5. Flush: flush in 2nd EXEC cycle of FDIV → IDLE next edge, wb_valid never asserts. Flush in WB simultaneous with wb_grant → no write.
6. Reset: reset=0 during WB → all outputs 0 next edge; issue_valid while busy is not accepted (issue_ready=0, no second fpu_start).
